// File: rtl/tmr_serial_tx.sv
// Repetition-coded serial transmitter: each payload bit is sent REP times, LSB first, framed by start/stop fields.
// Optional even-parity field enabled by defining TMR_TX_PARITY_EN.
module tmr_serial_tx #(
  parameter int DATA_W   = 8,
  parameter int REP      = 3,
  parameter int BAUD_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              done
);

  localparam int DW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int RW = (REP > 1) ? $clog2(REP) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(BAUD_DIV - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef TMR_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]        state;
  logic [DW-1:0]     div_cnt;
  logic [RW-1:0]     rep_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shr;
  logic              chip_end;
  logic              field_end;
  logic              bit_last;
  logic              accept;
`ifdef TMR_TX_PARITY_EN
  logic              par;
`endif

  assign in_ready  = (state == IDLE) && !rst;
  assign tx_busy   = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign chip_end  = (div_cnt == DIV_LAST);
  assign field_end = chip_end && (rep_cnt == REP_LAST);
  assign bit_last  = (bit_cnt == BIT_LAST);
  assign shr       = shreg >> 1;

  // tx_out is loaded with the value of the field being entered, so the line
  // changes exactly on the chip boundary with no combinational path to the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      rep_cnt <= '0;
      bit_cnt <= '0;
      tx_out  <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        div_cnt <= '0;
        rep_cnt <= '0;
        bit_cnt <= '0;
        if (accept) begin
          state  <= START;
          tx_out <= 1'b0;
        end
      end else begin
        div_cnt <= chip_end ? '0 : div_cnt + 1'b1;
        if (chip_end) begin
          rep_cnt <= field_end ? '0 : rep_cnt + 1'b1;
        end
        if (field_end) begin
          case (state)
            START: begin
              state  <= DATA;
              tx_out <= shreg[0];
            end
            DATA: begin
              if (bit_last) begin
                bit_cnt <= '0;
`ifdef TMR_TX_PARITY_EN
                state   <= PARITY;
                tx_out  <= par;
`else
                state   <= STOP;
                tx_out  <= 1'b1;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx_out  <= shr[0];
              end
            end
`ifdef TMR_TX_PARITY_EN
            PARITY: begin
              state  <= STOP;
              tx_out <= 1'b1;
            end
`endif
            default: begin
              state  <= IDLE;
              tx_out <= 1'b1;
              done   <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  // Payload path carries no reset; it is only consumed after a handshake reloads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= in_data;
    end else if ((state == DATA) && field_end && !bit_last) begin
      shreg <= shr;
    end
  end

`ifdef TMR_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (accept) begin
      par <= ^in_data;
    end
  end
`endif

endmodule

// File: tb/tb_tmr_serial_tx.sv
// Directed bench for tmr_serial_tx (DATA_W=8, REP=3, BAUD_DIV=2) with a majority-vote loopback model.
// Parity cases are compiled in when TMR_TX_PARITY_EN is defined.
module tb_tmr_serial_tx;

  localparam int DATA_W = 8;
  localparam int REP    = 3;
  localparam int BD     = 2;
`ifdef TMR_TX_PARITY_EN
  localparam int NF = DATA_W + 3;
`else
  localparam int NF = DATA_W + 2;
`endif
  localparam int FL = NF * REP * BD;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              tx_out;
  logic              tx_busy;
  logic              done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [127:0] tx_tr, busy_tr, rdy_tr, done_tr, fmask;
  int           done_at;
  bit           scramble;
  int           rst_at;

  tmr_serial_tx #(.DATA_W(DATA_W), .REP(REP), .BAUD_DIV(BD)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .tx_out   (tx_out),
    .tx_busy  (tx_busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_trace(input logic [7:0] w);
    logic [127:0] t;
    int c, f;
    t = '0;
    for (int k = 1; k <= FL; k++) begin
      c = (k - 1) / BD;
      f = c / REP;
      if (f == 0)            t[k] = 1'b0;
      else if (f <= DATA_W)  t[k] = w[f-1];
`ifdef TMR_TX_PARITY_EN
      else if (f == DATA_W + 1) t[k] = ^w;
`endif
      else                   t[k] = 1'b1;
    end
    return t;
  endfunction

  function automatic logic [127:0] expand_chips(input logic [63:0] chips);
    logic [127:0] t;
    t = '0;
    for (int k = 1; k <= FL; k++) t[k] = chips[(k - 1) / BD];
    return t;
  endfunction

  function automatic logic [7:0] decode(input logic [127:0] tr, input bit flip);
    logic [7:0] w;
    int votes, c;
    logic b;
    for (int j = 0; j < DATA_W; j++) begin
      votes = 0;
      for (int r = 0; r < REP; r++) begin
        c = REP * (j + 1) + r;
        b = tr[c * BD + 1];
        if (flip && (r == REP / 2)) b = ~b;
        votes += int'(b);
      end
      w[j] = (votes > REP / 2);
    end
    return w;
  endfunction

  task automatic send(input logic [7:0] d, input bit hold);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("ready_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic capture(input int n);
    tx_tr = '0; busy_tr = '0; rdy_tr = '0; done_tr = '0;
    done_at = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      tx_tr[k]   = tx_out;
      busy_tr[k] = tx_busy;
      rdy_tr[k]  = in_ready;
      done_tr[k] = done;
      if (done && done_at == 0) done_at = k;
      if (scramble) in_data = 8'($urandom);
      if (rst_at != 0 && k == rst_at) rst = 1'b1;
      if (rst_at != 0 && k == rst_at + 1) rst = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] chips;
    logic [7:0]  w;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; scramble = 1'b0; rst_at = 0;
    fmask = ((128'd1 << FL) - 128'd1) << 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_out", tx_out, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", in_ready, 0);

    // reset held while a word is offered: it must not be taken
    in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_wins_busy", tx_busy, 0);
    check("ready_after_rst", in_ready, 1);

    // basic 0xA5 frame against hand-derived chip pattern
`ifdef TMR_TX_PARITY_EN
    chips = 64'h1_C71C_0E38;
`else
    chips = 64'h3F1C_0E38;
`endif
    send(8'hA5, 1'b0);
    capture(FL + 2);
    check("a5_trace", tx_tr & fmask, expand_chips(chips));
    check("a5_busy_cycles", $countones(busy_tr), FL);
    check("a5_done_at", done_at, FL + 1);
    check("a5_done_count", $countones(done_tr), 1);
    check("a5_ready_in_frame", $countones(rdy_tr & fmask), 0);
    check("a5_idle_high", tx_tr[FL+1], 1);

    // back-to-back 0x00 then 0xFF with in_valid held
    send(8'h00, 1'b1);
    in_data = 8'hFF;
    capture(FL + 1);
    check("b2b0_trace", tx_tr & fmask, model_trace(8'h00));
    check("b2b0_done_at", done_at, FL + 1);
    check("b2b0_ready_done_cycle", rdy_tr[FL+1], 1);
    check("b2b0_gap_high", tx_tr[FL+1], 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    capture(FL + 1);
    check("b2b1_trace", tx_tr & fmask, model_trace(8'hFF));
    check("b2b1_data_ones", tx_tr[REP*BD+1 +: DATA_W*REP*BD], {(DATA_W*REP*BD){1'b1}});
    check("b2b1_done_at", done_at, FL + 1);

    // input word changes every cycle during the frame
    send(8'h3C, 1'b0);
    scramble = 1'b1;
    capture(FL + 1);
    scramble = 1'b0;
    check("stab_decode", decode(tx_tr, 1'b0), 8'h3C);
    check("stab_trace", tx_tr & fmask, model_trace(8'h3C));
    check("stab_ready_low", $countones(rdy_tr & fmask), 0);

    // reset pulse sampled at the end of frame cycle 25
    rst_at = 25;
    send(8'h5A, 1'b0);
    capture(FL + 2);
    rst_at = 0;
    check("mid_rst_tx_out", tx_tr[26], 1);
    check("mid_rst_busy", busy_tr[26], 0);
    check("mid_rst_busy_cycles", $countones(busy_tr), 25);
    check("mid_rst_no_done", $countones(done_tr), 0);
    check("mid_rst_ready", rdy_tr[27], 1);
    send(8'h81, 1'b0);
    capture(FL + 1);
    check("post_rst_trace", tx_tr & fmask, model_trace(8'h81));
    check("post_rst_done_at", done_at, FL + 1);

    // loopback through a 2-of-3 voter with the middle chip of each bit inverted
    for (int i = 0; i < 100; i++) begin
      w = 8'($urandom);
      send(w, 1'b0);
      capture(FL + 1);
      check("loopback", decode(tx_tr, 1'b1), w);
    end

`ifdef TMR_TX_PARITY_EN
    send(8'h07, 1'b0);
    capture(FL + 2);
    check("par07_field", tx_tr[(DATA_W+1)*REP*BD+1 +: REP*BD], {(REP*BD){1'b1}});
    check("par07_busy_cycles", $countones(busy_tr), 66);
    check("par07_done_at", done_at, 67);
    send(8'h03, 1'b0);
    capture(FL + 1);
    check("par03_field", tx_tr[(DATA_W+1)*REP*BD+1 +: REP*BD], {(REP*BD){1'b0}});
    check("par03_trace", tx_tr & fmask, model_trace(8'h03));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
